// File: rtl/heat_column_engine.sv
// rtl/heat_column_engine.sv - one column of the 2-D heat-diffusion grid, one row updated per step
//
// Ports:
//   clk, reset (async, active-high)
//   height      : index of top row (rows = height+1), sampled during INIT
//   init_value  : value written to every row during INIT
//   k_coef      : diffusion coefficient, same fixed-point format as the data
//   src_mask    : bit r set makes row r a fixed source forced to src_value
//   node_left/node_right : neighbouring columns' node_center
//   step_start  : pulse in IDLE processes the current row
//   node_center : time-n value of the current row, row_idx : current row
//   ready       : high in IDLE, step_done/sweep_done : single-cycle completion pulses
// Optional feature macro: HEAT_COLUMN_READBACK_EN adds rd_addr/rd_data, an independent
// 1-cycle-latency read port into the column RAM.
module heat_column_engine #(
    parameter int DATA_W    = 32,
    parameter int FRAC_W    = 27,
    parameter int ROW_BITS  = 8,
    parameter int EDGE_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ROW_BITS-1:0]      height,
    input  logic [DATA_W-1:0]        init_value,
    input  logic [DATA_W-1:0]        k_coef,
    input  logic [(2**ROW_BITS)-1:0] src_mask,
    input  logic [DATA_W-1:0]        src_value,
    input  logic [DATA_W-1:0]        node_left,
    input  logic [DATA_W-1:0]        node_right,
    input  logic                     step_start,
`ifdef HEAT_COLUMN_READBACK_EN
    input  logic [ROW_BITS-1:0]      rd_addr,
    output logic [DATA_W-1:0]        rd_data,
`endif
    output logic [DATA_W-1:0]        node_center,
    output logic [ROW_BITS-1:0]      row_idx,
    output logic                     ready,
    output logic                     step_done,
    output logic                     sweep_done
);

    localparam int ROWS   = 2**ROW_BITS;
    localparam int LAP_W  = DATA_W + 3;
    localparam int PROD_W = LAP_W + DATA_W;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_WAIT,
        S_CALC,
        S_WR
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_BITS-1:0] row_idx_q, row_idx_d;
    logic [ROW_BITS-1:0] init_cnt_q, init_cnt_d;
    logic [ROW_BITS-1:0] height_q, height_d;
    logic [DATA_W-1:0]   bottom_q, bottom_d;
    logic [DATA_W-1:0]   center_q, center_d;
    logic [DATA_W-1:0]   down_q, down_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                step_done_q, step_done_d;
    logic                sweep_done_q, sweep_done_d;

    logic [DATA_W-1:0]   mem [ROWS];
    logic [DATA_W-1:0]   ram_q;
    logic                mem_we;
    logic                rd_en;
    logic [ROW_BITS-1:0] mem_waddr;
    logic [ROW_BITS-1:0] mem_raddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                     at_top;
    logic                     at_bot;
    logic signed [DATA_W-1:0] c_s, up_s, down_s, edge_s, left_s, right_s, k_s;
    logic signed [LAP_W-1:0]  lap;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] sum;
    logic [PROD_W-DATA_W:0]   sum_hi;
    logic [DATA_W-1:0]        sat_val;
    logic [DATA_W-1:0]        calc_val;

    assign at_top = (row_idx_q == height_q);
    assign at_bot = (row_idx_q == '0);

    // Row 0's time-n value lives in bottom_reg because center_reg is reused for the
    // row above while the sweep walks upward.
    assign c_s     = at_bot ? bottom_q : center_q;
    assign edge_s  = (EDGE_MODE != 0) ? c_s : '0;
    assign up_s    = at_top ? edge_s : ram_q;
    assign down_s  = at_bot ? edge_s : down_q;
    assign left_s  = node_left;
    assign right_s = node_right;
    assign k_s     = k_coef;

    assign lap  = LAP_W'(up_s) + LAP_W'(down_s) + LAP_W'(left_s) + LAP_W'(right_s)
                - (LAP_W'(c_s) <<< 2);
    assign prod = PROD_W'(lap) * PROD_W'(k_s);
    assign sum  = PROD_W'(c_s) + (prod >>> FRAC_W);

    // The sum fits DATA_W only when every bit above the DATA_W sign bit matches it.
    assign sum_hi = sum[PROD_W-1:DATA_W-1];

    always_comb begin
        sat_val = sum[DATA_W-1:0];
        if (!(&sum_hi) && (|sum_hi)) begin
            sat_val = sum[PROD_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    assign calc_val = src_mask[row_idx_q] ? src_value : sat_val;

    // The row above has not been rewritten yet this sweep, so the RAM still holds its time-n value.
    assign mem_raddr = at_top ? '0 : row_idx_q + ROW_BITS'(1);

    always_comb begin
        state_d      = state_q;
        row_idx_d    = row_idx_q;
        init_cnt_d   = init_cnt_q;
        height_d     = height_q;
        bottom_d     = bottom_q;
        center_d     = center_q;
        down_d       = down_q;
        result_d     = result_q;
        step_done_d  = 1'b0;
        sweep_done_d = 1'b0;
        mem_we       = 1'b0;
        rd_en        = 1'b0;
        mem_waddr    = row_idx_q;
        mem_wdata    = result_q;

        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = init_cnt_q;
                mem_wdata = init_value;
                bottom_d  = init_value;
                center_d  = init_value;
                down_d    = '0;
                height_d  = height;
                row_idx_d = '0;
                if (init_cnt_q == height) begin
                    init_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + ROW_BITS'(1);
                end
            end
            S_IDLE: begin
                if (step_start) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                rd_en   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                result_d = calc_val;
                state_d  = S_WR;
            end
            S_WR: begin
                mem_we      = 1'b1;
                step_done_d = 1'b1;
                if (at_bot) begin
                    bottom_d = result_q;
                end
                if (at_top) begin
                    // Wrapping to row 0: its time-n value is the old bottom_reg.
                    center_d     = bottom_q;
                    down_d       = '0;
                    row_idx_d    = '0;
                    sweep_done_d = 1'b1;
                end else begin
                    down_d    = c_s;
                    center_d  = ram_q;
                    row_idx_d = row_idx_q + ROW_BITS'(1);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            row_idx_q    <= '0;
            init_cnt_q   <= '0;
            height_q     <= '0;
            bottom_q     <= '0;
            center_q     <= '0;
            down_q       <= '0;
            result_q     <= '0;
            step_done_q  <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_idx_q    <= row_idx_d;
            init_cnt_q   <= init_cnt_d;
            height_q     <= height_d;
            bottom_q     <= bottom_d;
            center_q     <= center_d;
            down_q       <= down_d;
            result_q     <= result_d;
            step_done_q  <= step_done_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    // Column RAM: kept free of reset so it maps onto block RAM; INIT rewrites it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_en) begin
            ram_q <= mem[mem_raddr];
        end
    end

`ifdef HEAT_COLUMN_READBACK_EN
    logic [DATA_W-1:0] rd_data_q;

    // Read-before-write: a read of the row being written returns the old value.
    always_ff @(posedge clk) begin
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;
`endif

    assign node_center = c_s;
    assign row_idx     = row_idx_q;
    assign ready       = (state_q == S_IDLE);
    assign step_done   = step_done_q;
    assign sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_heat_column_engine.sv
// tb/tb_heat_column_engine.sv - self-checking bench for heat_column_engine, both edge modes
module tb_heat_column_engine;

    localparam int RB = 4;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [RB-1:0] height;
    logic [31:0]   init_value, k_coef, src_value, node_left, node_right;
    logic [NR-1:0] src_mask;
    logic          step_start;

    logic [31:0]   nc0, nc1;
    logic [RB-1:0] ridx0, ridx1;
    logic          rdy0, rdy1, sd0, sd1, swd0, swd1;

    logic [31:0]   nc   [2];
    logic [RB-1:0] ridx [2];
    logic          rdy  [2];
    logic          sd   [2];
    logic          swd  [2];

    assign nc[0] = nc0;     assign nc[1] = nc1;
    assign ridx[0] = ridx0; assign ridx[1] = ridx1;
    assign rdy[0] = rdy0;   assign rdy[1] = rdy1;
    assign sd[0] = sd0;     assign sd[1] = sd1;
    assign swd[0] = swd0;   assign swd[1] = swd1;

    always #5 clk = ~clk;

    heat_column_engine #(.DATA_W(32), .FRAC_W(27), .ROW_BITS(RB), .EDGE_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .height(height), .init_value(init_value),
        .k_coef(k_coef), .src_mask(src_mask), .src_value(src_value),
        .node_left(node_left), .node_right(node_right), .step_start(step_start),
        .node_center(nc0), .row_idx(ridx0), .ready(rdy0),
        .step_done(sd0), .sweep_done(swd0)
    );

    heat_column_engine #(.DATA_W(32), .FRAC_W(27), .ROW_BITS(RB), .EDGE_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .height(height), .init_value(init_value),
        .k_coef(k_coef), .src_mask(src_mask), .src_value(src_value),
        .node_left(node_left), .node_right(node_right), .step_start(step_start),
        .node_center(nc1), .row_idx(ridx1), .ready(rdy1),
        .step_done(sd1), .sweep_done(swd1)
    );

    int checks = 0;
    int failures = 0;

    // Reference column: prev holds time-n values, cur collects the sweep's results.
    logic signed [31:0] prev [2][NR];
    logic signed [31:0] cur  [2][NR];
    logic [31:0]        cap  [2][NR];
    int                 h_m;
    int                 row_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rval();
        return 32'($urandom_range(0, 32'h3FFF_FFFF)) - 32'h2000_0000;
    endfunction

    // u' = c + k*(laplacian), real-valued product truncated toward -inf, then clamped.
    function automatic logic [31:0] diffuse(input logic signed [31:0] c, input logic signed [31:0] up,
                                            input logic signed [31:0] dn, input logic signed [31:0] l,
                                            input logic signed [31:0] rt, input logic signed [31:0] k);
        logic signed [95:0] lap, s;
        lap = 96'(up) + 96'(dn) + 96'(l) + 96'(rt) - 4 * 96'(c);
        s   = 96'(c) + ((lap * 96'(k)) >>> 27);
        if (s > 96'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -96'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    function automatic logic [31:0] expect_row(input int e, input int r);
        logic signed [31:0] c, up, dn, ed;
        c  = prev[e][r];
        ed = (e == 1) ? c : 32'sd0;
        if (r == h_m) up = ed; else up = prev[e][r+1];
        if (r == 0) dn = ed; else dn = prev[e][r-1];
        if (src_mask[r]) return src_value;
        return diffuse(c, up, dn, node_left, node_right, k_coef);
    endfunction

    task automatic do_reset(input int h, input logic [31:0] init);
        int cnt;
        reset = 1'b1;
        step_start = 1'b0;
        height = RB'(h);
        init_value = init;
        tick();
        for (int e = 0; e < 2; e++) begin
            chk($sformatf("rst_nc%0d", e), nc[e], 32'h0);
            chk($sformatf("rst_row%0d", e), 32'(ridx[e]), 32'h0);
            chk($sformatf("rst_ready%0d", e), 32'(rdy[e]), 32'h0);
            chk($sformatf("rst_sdone%0d", e), 32'(sd[e]), 32'h0);
        end
        reset = 1'b0;
        cnt = 0;
        while (rdy[0] !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("init_cycles", 32'(cnt), 32'(h + 1));
        chk("init_ready1", 32'(rdy[1]), 32'h1);
        h_m = h;
        row_m = 0;
        for (int e = 0; e < 2; e++) begin
            for (int r = 0; r < NR; r++) begin
                prev[e][r] = init;
                cur[e][r]  = init;
            end
        end
    endtask

    task automatic do_step(input bit poke);
        logic [31:0] ex [2];
        bit top;
        top = (row_m == h_m);
        for (int e = 0; e < 2; e++) begin
            chk($sformatf("pre_nc%0d_r%0d", e, row_m), nc[e], prev[e][row_m]);
            chk($sformatf("pre_row%0d", e), 32'(ridx[e]), 32'(row_m));
            cap[e][row_m] = nc[e];
            ex[e] = expect_row(e, row_m);
        end
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        chk("busy_ready", 32'(rdy[0]), 32'h0);
        tick();
        if (poke) step_start = 1'b1;
        tick();
        step_start = 1'b0;
        tick();
        chk("early_sdone", 32'(sd[0]), 32'h0);
        tick();
        for (int e = 0; e < 2; e++) begin
            chk($sformatf("sdone%0d", e), 32'(sd[e]), 32'h1);
            chk($sformatf("swdone%0d", e), 32'(swd[e]), 32'(top));
            chk($sformatf("done_ready%0d", e), 32'(rdy[e]), 32'h1);
        end
        for (int e = 0; e < 2; e++) cur[e][row_m] = ex[e];
        if (top) begin
            prev = cur;
            row_m = 0;
        end else begin
            row_m++;
        end
        for (int e = 0; e < 2; e++) begin
            chk($sformatf("post_row%0d", e), 32'(ridx[e]), 32'(row_m));
            chk($sformatf("post_nc%0d_r%0d", e, row_m), nc[e], prev[e][row_m]);
        end
        tick();
        chk("sdone_pulse", 32'(sd[0]), 32'h0);
        chk("idle_hold", 32'(rdy[0]), 32'h1);
        chk("idle_row", 32'(ridx[0]), 32'(row_m));
    endtask

    // mode 0: hold neighbours, 1: moderate random neighbours, 2: full-range random neighbours
    task automatic run_sweep(input int mode);
        for (int i = 0; i <= h_m; i++) begin
            if (mode == 1) begin
                node_left = rval();
                node_right = rval();
            end else if (mode == 2) begin
                node_left = $urandom;
                node_right = $urandom;
            end
            do_step(i == 2);
        end
    endtask

    initial begin
        reset = 1'b1;
        step_start = 1'b0;
        height = '0;
        init_value = '0;
        k_coef = '0;
        src_mask = '0;
        src_value = '0;
        node_left = '0;
        node_right = '0;

        // Reset and INIT duration
        do_reset(7, 32'h0);

        // Fixed source spreading: k=0.25, row 3 held at 2.0
        k_coef = 32'h0200_0000;
        src_mask = 16'h0008;
        src_value = 32'h1000_0000;
        run_sweep(0);
        run_sweep(0);
        for (int e = 0; e < 2; e++) chk($sformatf("src_row3_%0d", e), cap[e][3], 32'h1000_0000);
        run_sweep(0);
        for (int e = 0; e < 2; e++) begin
            chk($sformatf("src_row2_%0d", e), cap[e][2], 32'h0400_0000);
            chk($sformatf("src_row4_%0d", e), cap[e][4], 32'h0400_0000);
        end

        // Edge modes: uniform 1.0 field
        src_mask = '0;
        do_reset(7, 32'h0800_0000);
        node_left = 32'h0800_0000;
        node_right = 32'h0800_0000;
        run_sweep(0);
        run_sweep(0);
        chk("dirichlet_row0", cap[0][0], 32'h0600_0000);
        chk("dirichlet_row7", cap[0][7], 32'h0600_0000);
        chk("dirichlet_row3", cap[0][3], 32'h0800_0000);
        chk("insulated_row0", cap[1][0], 32'h0800_0000);
        chk("insulated_row7", cap[1][7], 32'h0800_0000);

        // Saturation, positive then negative
        k_coef = 32'h0800_0000;
        do_reset(7, 32'h7C00_0000);
        node_left = 32'h7F33_3333;
        node_right = 32'h7F33_3333;
        run_sweep(0);
        run_sweep(0);
        for (int e = 0; e < 2; e++) chk($sformatf("sat_pos%0d", e), cap[e][3], 32'h7FFF_FFFF);
        do_reset(7, 32'h8400_0000);
        node_left = 32'h80CC_CCCD;
        node_right = 32'h80CC_CCCD;
        run_sweep(0);
        run_sweep(0);
        for (int e = 0; e < 2; e++) chk($sformatf("sat_neg%0d", e), cap[e][3], 32'h8000_0000);

        // Single-row column: every step is a sweep
        k_coef = 32'h0100_0000;
        do_reset(0, rval());
        for (int i = 0; i < 3; i++) begin
            node_left = rval();
            node_right = rval();
            do_step(1'b0);
        end

        // Randomized columns, coefficients, sources and neighbours
        for (int it = 0; it < 3; it++) begin
            do_reset($urandom_range(1, 15), rval());
            for (int s = 0; s < 3; s++) begin
                k_coef = $urandom_range(0, 32'h0200_0000);
                src_mask = NR'($urandom & $urandom);
                src_value = rval();
                run_sweep(1);
            end
        end
        do_reset(9, $urandom);
        k_coef = $urandom_range(0, 32'h0800_0000);
        src_mask = '0;
        run_sweep(2);
        run_sweep(2);

        // Reset in the middle of CALC
        k_coef = 32'h0100_0000;
        do_reset(7, rval());
        node_left = rval();
        node_right = rval();
        for (int i = 0; i < 3; i++) do_step(1'b0);
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        for (int e = 0; e < 2; e++) begin
            chk($sformatf("abort_nc%0d", e), nc[e], 32'h0);
            chk($sformatf("abort_row%0d", e), 32'(ridx[e]), 32'h0);
            chk($sformatf("abort_ready%0d", e), 32'(rdy[e]), 32'h0);
            chk($sformatf("abort_sdone%0d", e), 32'(sd[e]), 32'h0);
        end
        k_coef = 32'h0;
        src_mask = '0;
        do_reset(7, 32'h0123_4567);
        run_sweep(1);
        run_sweep(1);
        for (int r = 0; r < 8; r++) chk($sformatf("reinit_row%0d", r), cap[0][r], 32'h0123_4567);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
